// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for the EX stage.
// Carries register-address metadata only; datapath pipeline registers are elsewhere.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  ex_is_load
);

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_WB      = 2'b01;
  localparam logic [1:0] SEL_MEM     = 2'b10;

  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  logic                  ex_uses_rt_q, ex_uses_rt_d;
  logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;
  logic                  ex_rw_q, ex_rw_d;
  logic                  ex_mr_q, ex_mr_d;

  logic [REG_ADDR_W-1:0] mem_dst_q;
  logic                  mem_rw_q;
  logic                  mem_mr_q;

  logic [REG_ADDR_W-1:0] wb_dst_q;
  logic                  wb_rw_q;

  logic mem_hits_rs, wb_hits_rs, mem_hits_rt, wb_hits_rt;

  assign stall = ex_mr_q && (ex_dst_q != '0) &&
                 ((ex_dst_q == id_rs) || (id_uses_rt && (ex_dst_q == id_rt)));

  // A stalled or flushed instruction leaves ID as an all-zero bubble.
  always_comb begin
    ex_rs_d      = id_rs;
    ex_rt_d      = id_rt;
    ex_uses_rt_d = id_uses_rt;
    ex_dst_d     = id_dst;
    ex_rw_d      = id_reg_write;
    ex_mr_d      = id_mem_read;
    if (stall || flush) begin
      ex_rs_d      = '0;
      ex_rt_d      = '0;
      ex_uses_rt_d = 1'b0;
      ex_dst_d     = '0;
      ex_rw_d      = 1'b0;
      ex_mr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_uses_rt_q <= 1'b0;
      ex_dst_q     <= '0;
      ex_rw_q      <= 1'b0;
      ex_mr_q      <= 1'b0;
      mem_dst_q    <= '0;
      mem_rw_q     <= 1'b0;
      mem_mr_q     <= 1'b0;
      wb_dst_q     <= '0;
      wb_rw_q      <= 1'b0;
    end else begin
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_uses_rt_q <= ex_uses_rt_d;
      ex_dst_q     <= ex_dst_d;
      ex_rw_q      <= ex_rw_d;
      ex_mr_q      <= ex_mr_d;
      mem_dst_q    <= ex_dst_q;
      mem_rw_q     <= ex_rw_q;
      mem_mr_q     <= ex_mr_q;
      wb_dst_q     <= mem_dst_q;
      wb_rw_q      <= mem_rw_q;
    end
  end

  assign mem_hits_rs = mem_rw_q && (mem_dst_q != '0) && (mem_dst_q == ex_rs_q);
  assign wb_hits_rs  = wb_rw_q  && (wb_dst_q  != '0) && (wb_dst_q  == ex_rs_q);
  assign mem_hits_rt = mem_rw_q && (mem_dst_q != '0) && (mem_dst_q == ex_rt_q);
  assign wb_hits_rt  = wb_rw_q  && (wb_dst_q  != '0) && (wb_dst_q  == ex_rt_q);

  // The MEM-stage producer is younger than WB, so it takes priority.
  always_comb begin
    fwd_a_sel = SEL_REGFILE;
    fwd_b_sel = SEL_REGFILE;
    if (mem_hits_rs)
      fwd_a_sel = SEL_MEM;
    else if (wb_hits_rs)
      fwd_a_sel = SEL_WB;
    if (ex_uses_rt_q) begin
      if (mem_hits_rt)
        fwd_b_sel = SEL_MEM;
      else if (wb_hits_rt)
        fwd_b_sel = SEL_WB;
    end
  end

  assign ex_is_load = mem_mr_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed instruction stream, a stage-array reference
// model compared every cycle, plus literal expectations at key points.
module tb_fwd_hazard_ctrl;

  localparam int W = 5;

  typedef struct packed {
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic         uses;
    logic [W-1:0] dst;
    logic         rw;
    logic         mr;
  } instr_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] id_rs, id_rt, id_dst;
  logic         id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [1:0]   fwd_a_sel, fwd_b_sel;
  logic         stall, ex_is_load;

  int errors = 0;
  int checks = 0;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t pipe [3];

  fwd_hazard_ctrl #(.REG_ADDR_W(W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .ex_is_load(ex_is_load)
  );

  always #5 clk = ~clk;

  function automatic logic modelStall();
    instr_t ex;
    ex = pipe[0];
    return ex.mr && ex.dst != 0 && (ex.dst == id_rs || (id_uses_rt && ex.dst == id_rt));
  endfunction

  // Search older instructions youngest-first for the newest writer of a register.
  function automatic logic [1:0] modelSel(input logic [W-1:0] src, input logic used);
    if (!used || src == 0) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].rw && pipe[k].dst == src) return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] <= '0;
    end else begin
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      if (modelStall() || flush) pipe[0] <= '0;
      else pipe[0] <= '{rs: id_rs, rt: id_rt, uses: id_uses_rt, dst: id_dst,
                        rw: id_reg_write, mr: id_mem_read};
    end
  end

  task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_a", fwd_a_sel, modelSel(pipe[0].rs, 1'b1));
    checkOutput("model_b", fwd_b_sel, modelSel(pipe[0].rt, pipe[0].uses));
    checkOutput("model_stall", {1'b0, stall}, {1'b0, modelStall()});
    checkOutput("model_load", {1'b0, ex_is_load}, {1'b0, pipe[1].mr});
  end

  task automatic applyStimulus(input int rs, input int rt, input bit uses, input int dst,
                               input bit rw, input bit mr, input bit fl);
    id_rs        = W'(rs);
    id_rt        = W'(rt);
    id_uses_rt   = uses;
    id_dst       = W'(dst);
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    nop();
    #2;
    checkOutput("reset_a", fwd_a_sel, 2'b00);
    checkOutput("reset_b", fwd_b_sel, 2'b00);
    checkOutput("reset_stall", {1'b0, stall}, 2'b00);
    checkOutput("reset_load", {1'b0, ex_is_load}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back producer/consumer of $8
    applyStimulus(1, 2, 1, 8, 1, 0, 0);  step();
    applyStimulus(8, 9, 1, 10, 1, 0, 0); step();
    #1;
    checkOutput("b2b_mem_a", fwd_a_sel, 2'b10);
    checkOutput("b2b_mem_b", fwd_b_sel, 2'b00);
    applyStimulus(3, 8, 1, 11, 1, 0, 0); step();
    #1;
    checkOutput("b2b_wb_b", fwd_b_sel, 2'b01);
    checkOutput("b2b_wb_a", fwd_a_sel, 2'b00);

    // Two writers of $5: MEM wins over WB
    applyStimulus(0, 0, 0, 5, 1, 0, 0); step();
    applyStimulus(0, 0, 0, 5, 1, 0, 0); step();
    applyStimulus(5, 0, 0, 12, 1, 0, 0); step();
    #1;
    checkOutput("double_a", fwd_a_sel, 2'b10);

    // Load-use on rt
    applyStimulus(1, 0, 0, 4, 1, 1, 0);  step();
    applyStimulus(6, 4, 1, 13, 1, 0, 0);
    #1;
    checkOutput("lu_stall", {1'b0, stall}, 2'b01);
    step();
    #1;
    checkOutput("lu_stall_gone", {1'b0, stall}, 2'b00);
    checkOutput("lu_ex_is_load", {1'b0, ex_is_load}, 2'b01);
    step();
    #1;
    checkOutput("lu_fwd_b", fwd_b_sel, 2'b01);
    checkOutput("lu_no_stall", {1'b0, stall}, 2'b00);

    // Load followed by non-rt reader of the same number
    applyStimulus(1, 0, 0, 4, 1, 1, 0);  step();
    applyStimulus(6, 4, 0, 14, 1, 0, 0);
    #1;
    checkOutput("nouse_stall", {1'b0, stall}, 2'b00);
    step();
    #1;
    checkOutput("nouse_b", fwd_b_sel, 2'b00);

    // Register 0 is never forwarded or stalled on
    applyStimulus(0, 0, 0, 0, 1, 1, 0);  step();
    applyStimulus(0, 0, 1, 0, 1, 0, 0);
    #1;
    checkOutput("r0_stall", {1'b0, stall}, 2'b00);
    step();
    applyStimulus(0, 0, 1, 15, 1, 0, 0); step();
    #1;
    checkOutput("r0_a", fwd_a_sel, 2'b00);
    checkOutput("r0_b", fwd_b_sel, 2'b00);

    // Flushed producer of $7 must not be seen
    applyStimulus(0, 0, 0, 7, 1, 0, 1);  step();
    nop();                               step();
    applyStimulus(7, 7, 1, 16, 1, 0, 0);
    #1;
    checkOutput("flush_stall", {1'b0, stall}, 2'b00);
    step();
    #1;
    checkOutput("flush_a", fwd_a_sel, 2'b00);
    checkOutput("flush_b", fwd_b_sel, 2'b00);

    // Stall and flush in the same cycle
    applyStimulus(1, 0, 0, 9, 1, 1, 0);  step();
    applyStimulus(9, 0, 0, 17, 1, 0, 1);
    #1;
    checkOutput("sf_stall", {1'b0, stall}, 2'b01);
    step();
    nop();
    #1;
    checkOutput("sf_after", {1'b0, stall}, 2'b00);
    step(); step();

    // Asynchronous reset mid-stream with a $8 writer in MEM
    applyStimulus(0, 0, 0, 8, 1, 0, 0);  step();
    applyStimulus(8, 8, 1, 18, 1, 0, 0); step();
    #1;
    checkOutput("pre_rst_a", fwd_a_sel, 2'b10);
    checkOutput("pre_rst_b", fwd_b_sel, 2'b10);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_a", fwd_a_sel, 2'b00);
    checkOutput("async_rst_b", fwd_b_sel, 2'b00);
    checkOutput("async_rst_stall", {1'b0, stall}, 2'b00);
    step();
    rst = 1'b0;
    nop();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
